// File: rtl/nextpc_pkg.sv
// Shared types and default widths for the next-PC generator and run controller.
package nextpc_pkg;

  localparam int D_DEF  = 9;
  localparam int LW_DEF = 5;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/next_pc_ctrl_branch_lut.sv
// Branch-target table: one synchronous write port, one asynchronous read port.
// A same-cycle write to the index being read is seen only after the edge.
module branch_lut #(
  parameter int D  = 9,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [LW-1:0] waddr,
  input  logic [D-1:0]  wdata,
  input  logic [LW-1:0] raddr,
  output logic [D-1:0]  rdata
);

  localparam int N = 2 ** LW;

  logic [D-1:0] r_mem [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/next_pc_ctrl.sv
// Next-PC generator and start/halt run controller sitting in front of the PC register.
// next_pc is purely combinational; state, cycle counter and branch table are registered.
module next_pc_ctrl
  import nextpc_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int LW = LW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  cur_pc,
  input  logic          stall,
  input  logic          halt_instr,
  input  logic          branch_en,
  input  logic          branch_taken,
  input  logic          jump_rel,
  input  logic [D-1:0]  rel_off,
  input  logic [LW-1:0] lut_idx,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic [D-1:0]  next_pc,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [D-1:0]  w_lutData;

  branch_lut #(.D(D), .LW(LW)) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (lut_idx),
    .rdata (w_lutData)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // A start in RUN is a restart, so it keeps the FSM in RUN even alongside a halt.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = RUN;
      RUN:     if (!start && halt_instr && !stall) w_stateNext = DONE;
      DONE:    if (start) w_stateNext = RUN;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || start)                          r_cnt <= '0;
    else if (r_state == RUN && r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
  end

  always_comb begin
    next_pc = '0;
    if (!reset) begin
      case (r_state)
        RUN: begin
          if (start)                            next_pc = '0;
          else if (stall || halt_instr)         next_pc = cur_pc;
          else if (branch_en && branch_taken)   next_pc = jump_rel ? cur_pc + rel_off : w_lutData;
          else                                  next_pc = cur_pc + D'(1);
        end
        DONE:    next_pc = start ? '0 : cur_pc;
        default: next_pc = '0;
      endcase
    end
  end

  assign running   = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_next_pc_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stall, halt_instr, branch_en, branch_taken, jump_rel, lut_we;
  logic [8:0] cur_pc, rel_off, lut_wdata, next_pc;
  logic [4:0] lut_idx, lut_waddr;
  logic       running, done;
  logic [15:0] cycle_cnt;

  typedef struct {
    string       name;
    logic [8:0]  pc;
    logic        run;
    logic        dn;
    logic [15:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 clk = ~clk;

  next_pc_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cur_pc(cur_pc), .stall(stall),
    .halt_instr(halt_instr), .branch_en(branch_en), .branch_taken(branch_taken),
    .jump_rel(jump_rel), .rel_off(rel_off), .lut_idx(lut_idx), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .next_pc(next_pc),
    .running(running), .done(done), .cycle_cnt(cycle_cnt)
  );

  // Queue the expected outputs for the inputs currently driven, then advance one edge.
  task automatic applyStimulus(input string name, input logic [8:0] pc, input logic run,
                               input logic dn, input logic [15:0] cnt);
    exp_t e;
    e.name = name; e.pc = pc; e.run = run; e.dn = dn; e.cnt = cnt;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    nChecks += 4;
    if (next_pc !== e.pc) begin
      nErrors++;
      $display("[TB] FAIL %s next_pc got=%h exp=%h", e.name, next_pc, e.pc);
    end
    if (running !== e.run) begin
      nErrors++;
      $display("[TB] FAIL %s running got=%b exp=%b", e.name, running, e.run);
    end
    if (done !== e.dn) begin
      nErrors++;
      $display("[TB] FAIL %s done got=%b exp=%b", e.name, done, e.dn);
    end
    if (cycle_cnt !== e.cnt) begin
      nErrors++;
      $display("[TB] FAIL %s cycle_cnt got=%0d exp=%0d", e.name, cycle_cnt, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1; start = 0; stall = 0; halt_instr = 0; branch_en = 0; branch_taken = 0;
    jump_rel = 0; lut_we = 0; cur_pc = 9'h055; rel_off = 0; lut_wdata = 0; lut_idx = 0; lut_waddr = 0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus("reset", 9'h000, 0, 0, 0);
    reset = 0; cur_pc = 9'h005;
    applyStimulus("idle", 9'h000, 0, 0, 0);

    // Launch and run sequentially.
    start = 1; cur_pc = 9'h033;
    applyStimulus("idle_start", 9'h000, 0, 0, 0);
    start = 0; cur_pc = 9'h000;
    applyStimulus("seq0", 9'h001, 1, 0, 0);
    cur_pc = 9'h001;
    applyStimulus("seq1", 9'h002, 1, 0, 1);
    cur_pc = 9'h002;
    applyStimulus("seq2", 9'h003, 1, 0, 2);

    // Absolute branches through the table.
    lut_we = 1; lut_waddr = 5'd7; lut_wdata = 9'h120; cur_pc = 9'h003;
    applyStimulus("lut_wr7", 9'h004, 1, 0, 3);
    lut_we = 0; cur_pc = 9'h010; branch_en = 1; branch_taken = 1; jump_rel = 0; lut_idx = 5'd7;
    applyStimulus("br_abs_taken", 9'h120, 1, 0, 4);
    branch_taken = 0;
    applyStimulus("br_not_taken", 9'h011, 1, 0, 5);

    // Relative branch wrap and sequential wrap.
    cur_pc = 9'h003; branch_taken = 1; jump_rel = 1; rel_off = 9'h1FB;
    applyStimulus("br_rel_neg", 9'h1FE, 1, 0, 6);
    branch_en = 0; branch_taken = 0; jump_rel = 0; cur_pc = 9'h1FF;
    applyStimulus("seq_wrap", 9'h000, 1, 0, 7);

    // Halt blocked by stall, then accepted.
    cur_pc = 9'h040; halt_instr = 1; stall = 1;
    applyStimulus("halt_stalled", 9'h040, 1, 0, 8);
    stall = 0;
    applyStimulus("halt_accept", 9'h040, 1, 0, 9);
    halt_instr = 0;
    applyStimulus("done_hold", 9'h040, 0, 1, 10);
    cur_pc = 9'h041;
    applyStimulus("done_frozen", 9'h041, 0, 1, 10);
    start = 1;
    applyStimulus("done_start", 9'h000, 0, 1, 10);
    start = 0; cur_pc = 9'h000;
    applyStimulus("rerun", 9'h001, 1, 0, 0);

    // Same-cycle table write and read sees the old entry.
    lut_we = 1; lut_waddr = 5'd4; lut_wdata = 9'h011; cur_pc = 9'h001;
    applyStimulus("lut_wr4_old", 9'h002, 1, 0, 1);
    lut_wdata = 9'h0AA; cur_pc = 9'h002; branch_en = 1; branch_taken = 1; lut_idx = 5'd4;
    applyStimulus("lut_rw_same", 9'h011, 1, 0, 2);
    lut_we = 0;
    applyStimulus("lut_new", 9'h0AA, 1, 0, 3);
    stall = 1; cur_pc = 9'h022;
    applyStimulus("stall_branch", 9'h022, 1, 0, 4);
    stall = 0; branch_en = 0; branch_taken = 0;

    // Restart while running.
    start = 1; cur_pc = 9'h030;
    applyStimulus("run_restart", 9'h000, 1, 0, 5);
    start = 0; cur_pc = 9'h055;
    applyStimulus("after_restart", 9'h056, 1, 0, 0);

    // Reset mid-run aborts and clears the table.
    reset = 1;
    applyStimulus("reset_midrun", 9'h000, 1, 0, 1);
    reset = 0;
    applyStimulus("post_reset", 9'h000, 0, 0, 0);
    start = 1;
    applyStimulus("start2", 9'h000, 0, 0, 0);
    start = 0; branch_en = 1; branch_taken = 1; jump_rel = 0; lut_idx = 5'd7;
    applyStimulus("lut7_cleared", 9'h000, 1, 0, 0);

    // Counter saturation under a long stall.
    branch_en = 0; branch_taken = 0; stall = 1; cur_pc = 9'h060;
    repeat (65533) @(posedge clk);
    #1;
    applyStimulus("cnt_near_max", 9'h060, 1, 0, 16'd65534);
    applyStimulus("cnt_max", 9'h060, 1, 0, 16'hFFFF);
    applyStimulus("cnt_saturated", 9'h060, 1, 0, 16'hFFFF);

    @(posedge clk);
    #1;
    if (expQ.size() != 0) begin
      nErrors++;
      $display("[TB] FAIL queue_drain left=%0d required=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
